alu_ctrl: RTL and testbench

//   Command-side driver for the 8-bit combinational ALU (a, b, s -> out, z, n, c, v).

---
 rtl/alu_ctrl_if.sv | 51 +++++
 rtl/alu_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_if.sv
// Purpose : bundles the command, register-load, ALU-drive, result and debug
//           signals of alu_ctrl so one port connects sequencer, ALU and debug.
// Ports   : slave modport = the controller, master modport = the sequencer/ALU side.
// Latency/backpressure: none here; cmd_valid/cmd_ready handshake is owned by alu_ctrl.
interface alu_ctrl_if;
    // command handshake from the instruction sequencer
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_ra;
    logic [1:0] cmd_rb;
    logic [1:0] cmd_rd;
    logic       cmd_wb;
    // external register load
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    // combinational ALU
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_s;
    logic [7:0] alu_out;
    logic       alu_z;
    logic       alu_n;
    logic       alu_c;
    logic       alu_v;
    // results and debug read port
    logic [7:0] result;
    logic [3:0] flags;
    logic       done;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
        input  ld_en, ld_addr, ld_data,
        input  alu_out, alu_z, alu_n, alu_c, alu_v,
        input  dbg_addr,
        output cmd_ready, alu_a, alu_b, alu_s,
        output result, flags, done, dbg_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_wb,
        output ld_en, ld_addr, ld_data,
        output alu_out, alu_z, alu_n, alu_c, alu_v,
        output dbg_addr,
        input  cmd_ready, alu_a, alu_b, alu_s,
        input  result, flags, done, dbg_data
    );
endinterface

// File: rtl/alu_ctrl.sv
// Purpose : command-side driver for an 8-bit combinational ALU with a 4-entry
//           register file; reads operands, drives the ALU, captures result/flags,
//           optionally writes back and pulses done.
// Latency : accept at edge k -> capture at edge k+SETTLE, done high during that cycle.
// Backpressure: cmd_ready is high only in IDLE; one command per SETTLE+1 cycles.
// Ports   : clk, rst (async, active-high) plus the alu_ctrl_if slave modport.
module alu_ctrl #(
    // cycles the ALU inputs are held before capture; legal range 1..15
    parameter int unsigned SETTLE = 1
) (
    input  logic      clk,
    input  logic      rst,
    alu_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] rd_q, rd_d;
    logic       wb_q, wb_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [2:0] alu_s_q, alu_s_d;
    logic [7:0] result_q, result_d;
    logic [3:0] flags_q, flags_d;
    logic       done_q, done_d;
    logic [7:0] regs_q [4];
    logic       capture;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wb_d     = wb_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_s_d  = alu_s_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    // operands are snapshotted here; later loads cannot disturb them
                    alu_a_d = regs_q[bus.cmd_ra];
                    alu_b_d = regs_q[bus.cmd_rb];
                    alu_s_d = bus.cmd_op;
                    rd_d    = bus.cmd_rd;
                    wb_d    = bus.cmd_wb;
                    cnt_d   = CNT_INIT;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    capture  = 1'b1;
                    result_d = bus.alu_out;
                    flags_d  = {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v};
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_s_q  <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_s_q  <= alu_s_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    // Register file: write-back takes priority over an external load to the
    // same address; loads to other addresses land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (capture && wb_q && (rd_q == 2'(i))) begin
                    regs_q[i] <= bus.alu_out;
                end else if (bus.ld_en && (bus.ld_addr == 2'(i))) begin
                    regs_q[i] <= bus.ld_data;
                end
            end
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_s     = alu_s_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.done      = done_q;
    assign bus.dbg_data  = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_alu_ctrl.sv
// Purpose : directed bench for alu_ctrl, one instance at SETTLE=1 and one at
//           SETTLE=3, each wired to a small behavioural model of the team ALU.
// Latency/backpressure: inputs driven on the falling edge, outputs sampled there too.
module tb_alu_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_ctrl_if bus1 ();
    alu_ctrl_if bus3 ();

    alu_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    alu_ctrl #(.SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Team ALU model. Codes: 000 add, 001 sub, 010 and, 011 or, 100 not a,
    // 101 xor, 110 inc a, 111 pass a. c is the carry into bit 7 and
    // v = carry-in(7) ^ carry-out(7); both are 0 for logic ops.
    function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] s);
        logic [7:0] bb;
        logic [7:0] o;
        logic [7:0] lo;
        logic [8:0] full;
        logic       cin;
        logic       arith;
        bb    = b;
        cin   = 1'b0;
        arith = 1'b0;
        o     = 8'h00;
        case (s)
            3'b000:  arith = 1'b1;
            3'b001:  begin arith = 1'b1; bb = ~b; cin = 1'b1; end
            3'b010:  o = a & b;
            3'b011:  o = a | b;
            3'b100:  o = ~a;
            3'b101:  o = a ^ b;
            3'b110:  begin arith = 1'b1; bb = 8'h00; cin = 1'b1; end
            default: o = a;
        endcase
        lo   = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'b0, cin};
        full = {1'b0, a} + {1'b0, bb} + {8'b0, cin};
        if (arith) o = full[7:0];
        return {o, (o == 8'h00), o[7], arith & lo[7], arith & (lo[7] ^ full[8])};
    endfunction

    assign {bus1.alu_out, bus1.alu_z, bus1.alu_n, bus1.alu_c, bus1.alu_v} =
        alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_s);
    assign {bus3.alu_out, bus3.alu_z, bus3.alu_n, bus3.alu_c, bus3.alu_v} =
        alu_f(bus3.alu_a, bus3.alu_b, bus3.alu_s);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd1(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        bus1.dbg_addr = addr;
        #1;
        chk(tag, bus1.dbg_data, exp);
    endtask

    task automatic rd3(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        bus3.dbg_addr = addr;
        #1;
        chk(tag, bus3.dbg_data, exp);
    endtask

    // Called on a falling edge; returns on the next falling edge with ld_en low.
    task automatic load1(input logic [1:0] addr, input logic [7:0] data);
        bus1.ld_en = 1'b1; bus1.ld_addr = addr; bus1.ld_data = data;
        @(negedge clk);
        bus1.ld_en = 1'b0;
    endtask

    task automatic load3(input logic [1:0] addr, input logic [7:0] data);
        bus3.ld_en = 1'b1; bus3.ld_addr = addr; bus3.ld_data = data;
        @(negedge clk);
        bus3.ld_en = 1'b0;
    endtask

    task automatic cmd1(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [1:0] rd, input logic wb);
        bus1.cmd_valid = 1'b1; bus1.cmd_op = op; bus1.cmd_ra = ra;
        bus1.cmd_rb = rb; bus1.cmd_rd = rd; bus1.cmd_wb = wb;
    endtask

    task automatic cmd3(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [1:0] rd, input logic wb);
        bus3.cmd_valid = 1'b1; bus3.cmd_op = op; bus3.cmd_ra = ra;
        bus3.cmd_rb = rb; bus3.cmd_rd = rd; bus3.cmd_wb = wb;
    endtask

    // Three falling edges of DRIVE on the SETTLE=3 instance: busy, no done.
    task automatic drive3_chk(input string tag);
        for (int w = 0; w < 3; w++) begin
            if (w != 0) @(negedge clk);
            chk({tag, "_ready"}, 8'(bus3.cmd_ready), 8'h00);
            chk({tag, "_done"}, 8'(bus3.done), 8'h00);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_op = 3'd0; bus1.cmd_ra = 2'd0; bus1.cmd_rb = 2'd0;
        bus1.cmd_rd = 2'd0; bus1.cmd_wb = 1'b0; bus1.ld_en = 1'b0; bus1.ld_addr = 2'd0;
        bus1.ld_data = 8'h00; bus1.dbg_addr = 2'd0;
        bus3.cmd_valid = 1'b0; bus3.cmd_op = 3'd0; bus3.cmd_ra = 2'd0; bus3.cmd_rb = 2'd0;
        bus3.cmd_rd = 2'd0; bus3.cmd_wb = 1'b0; bus3.ld_en = 1'b0; bus3.ld_addr = 2'd0;
        bus3.ld_data = 8'h00; bus3.dbg_addr = 2'd0;

        // 1. asynchronous reset asserted mid-cycle clears everything at once
        @(negedge clk);
        load1(2'd0, 8'hAA);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_result", bus1.result, 8'h00);
        chk("rst_flags", 8'(bus1.flags), 8'h00);
        chk("rst_alu_a", bus1.alu_a, 8'h00);
        chk("rst_alu_b", bus1.alu_b, 8'h00);
        chk("rst_alu_s", 8'(bus1.alu_s), 8'h00);
        chk("rst_done", 8'(bus1.done), 8'h00);
        rd1("rst_r0", 2'd0, 8'h00);
        rd1("rst_r1", 2'd1, 8'h00);
        rd1("rst_r2", 2'd2, 8'h00);
        rd1("rst_r3", 2'd3, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready1", 8'(bus1.cmd_ready), 8'h01);
        chk("rst_ready3", 8'(bus3.cmd_ready), 8'h01);

        // 2. ADD 0x7F + 0x01 -> r2
        @(negedge clk);
        load1(2'd0, 8'h7F);
        load1(2'd1, 8'h01);
        cmd1(3'b000, 2'd0, 2'd1, 2'd2, 1'b1);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        chk("add_busy", 8'(bus1.cmd_ready), 8'h00);
        chk("add_nodone", 8'(bus1.done), 8'h00);
        chk("add_alu_a", bus1.alu_a, 8'h7F);
        chk("add_alu_b", bus1.alu_b, 8'h01);
        chk("add_alu_s", 8'(bus1.alu_s), 8'h00);
        @(negedge clk);
        chk("add_done", 8'(bus1.done), 8'h01);
        chk("add_result", bus1.result, 8'h80);
        chk("add_flags", 8'(bus1.flags), 8'h07);
        chk("add_ready", 8'(bus1.cmd_ready), 8'h01);
        rd1("add_r2", 2'd2, 8'h80);
        @(negedge clk);
        chk("add_done_drop", 8'(bus1.done), 8'h00);
        chk("add_hold_a", bus1.alu_a, 8'h7F);

        // 3. compare: SUB r3 - r3 with wb=0
        load1(2'd3, 8'h05);
        cmd1(3'b001, 2'd3, 2'd3, 2'd0, 1'b0);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        @(negedge clk);
        chk("sub_done", 8'(bus1.done), 8'h01);
        chk("sub_result", bus1.result, 8'h00);
        chk("sub_flags", 8'(bus1.flags), 8'h0A);
        rd1("sub_r0_kept", 2'd0, 8'h7F);

        // NOT ignores b at the ALU, but rb is still read and driven
        @(negedge clk);
        cmd1(3'b100, 2'd1, 2'd0, 2'd3, 1'b1);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        chk("not_alu_b", bus1.alu_b, 8'h7F);
        chk("not_alu_s", 8'(bus1.alu_s), 8'h04);
        @(negedge clk);
        chk("not_result", bus1.result, 8'hFE);
        chk("not_flags", 8'(bus1.flags), 8'h04);
        rd1("not_r3", 2'd3, 8'hFE);

        // 6a. load to rd on the capture edge loses to write-back
        @(negedge clk);
        cmd1(3'b000, 2'd0, 2'd1, 2'd0, 1'b1);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        load1(2'd0, 8'h33);
        chk("wb_win_done", 8'(bus1.done), 8'h01);
        rd1("wb_win_r0", 2'd0, 8'h80);

        // 6b. load to ra during DRIVE does not reach the in-flight operand
        @(negedge clk);
        cmd1(3'b000, 2'd1, 2'd1, 2'd3, 1'b1);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        load1(2'd1, 8'h10);
        chk("snap_result", bus1.result, 8'h02);
        chk("snap_flags", 8'(bus1.flags), 8'h00);
        rd1("snap_r3", 2'd3, 8'h02);
        rd1("snap_r1", 2'd1, 8'h10);

        // 6c. write-back and load to different addresses on the same edge
        @(negedge clk);
        cmd1(3'b000, 2'd0, 2'd1, 2'd2, 1'b1);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        load1(2'd3, 8'h44);
        chk("both_result", bus1.result, 8'h90);
        chk("both_flags", 8'(bus1.flags), 8'h04);
        rd1("both_r2", 2'd2, 8'h90);
        rd1("both_r3", 2'd3, 8'h44);

        // 4. SETTLE=3, cmd_valid held for three dependent commands
        @(negedge clk);
        load3(2'd0, 8'h03);
        load3(2'd1, 8'h04);
        cmd3(3'b000, 2'd0, 2'd1, 2'd2, 1'b1);
        #1;
        chk("s3_ready0", 8'(bus3.cmd_ready), 8'h01);
        @(negedge clk);
        cmd3(3'b000, 2'd2, 2'd1, 2'd3, 1'b1);
        drive3_chk("s3_c1");
        @(negedge clk);
        chk("s3_c1_done", 8'(bus3.done), 8'h01);
        chk("s3_c1_result", bus3.result, 8'h07);
        chk("s3_c1_flags", 8'(bus3.flags), 8'h00);
        chk("s3_c1_ready", 8'(bus3.cmd_ready), 8'h01);
        @(negedge clk);
        cmd3(3'b001, 2'd3, 2'd0, 2'd0, 1'b1);
        drive3_chk("s3_c2");
        @(negedge clk);
        chk("s3_c2_done", 8'(bus3.done), 8'h01);
        chk("s3_c2_result", bus3.result, 8'h0B);
        @(negedge clk);
        bus3.cmd_valid = 1'b0;
        drive3_chk("s3_c3");
        @(negedge clk);
        chk("s3_c3_done", 8'(bus3.done), 8'h01);
        chk("s3_c3_result", bus3.result, 8'h08);
        chk("s3_c3_flags", 8'(bus3.flags), 8'h02);
        @(negedge clk);
        chk("s3_idle_done", 8'(bus3.done), 8'h00);
        chk("s3_idle_ready", 8'(bus3.cmd_ready), 8'h01);
        rd3("s3_r0", 2'd0, 8'h08);
        rd3("s3_r2", 2'd2, 8'h07);
        rd3("s3_r3", 2'd3, 8'h0B);

        // 5. reset during DRIVE abandons the command
        @(negedge clk);
        cmd1(3'b010, 2'd0, 2'd1, 2'd2, 1'b1);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        chk("abort_busy", 8'(bus1.cmd_ready), 8'h00);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_nodone_rst", 8'(bus1.done), 8'h00);
        rst = 1'b0;
        #1;
        chk("abort_ready", 8'(bus1.cmd_ready), 8'h01);
        chk("abort_result", bus1.result, 8'h00);
        rd1("abort_r2", 2'd2, 8'h00);
        @(negedge clk);
        chk("abort_nodone", 8'(bus1.done), 8'h00);
        chk("abort_still_ready", 8'(bus1.cmd_ready), 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
